// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master.
// Converts a valid/ready command into an APB SETUP/ACCESS transfer and
// returns read data and error status on a valid/ready response port.
// A slave that holds pready low for too long is aborted by an ACCESS-phase timeout.
module apb_master_ctrl #(
  parameter int A_WIDTH  = 32,
  parameter int WD_WIDTH = 32,
  parameter int RD_WIDTH = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                i_pclk,
  input  logic                i_preset,
  // command port
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [A_WIDTH-1:0]  i_req_addr,
  input  logic [WD_WIDTH-1:0] i_req_wdata,
  // response port
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [RD_WIDTH-1:0] o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_rsp_timeout,
  // APB master side
  output logic [A_WIDTH-1:0]  o_paddr,
  output logic                o_pwrite,
  output logic [WD_WIDTH-1:0] o_pwdata,
  output logic                o_psel,
  output logic                o_penable,
  input  logic [RD_WIDTH-1:0] i_prdata,
  input  logic                i_pready,
  input  logic                i_pslverr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          to_hit;

  // The final allowed ACCESS cycle is reached; a pready in this cycle still wins.
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Outputs decoded from state only; psel/penable drop with the async reset.
  assign o_req_ready = (state == IDLE);
  assign o_psel      = (state == SETUP) || (state == ACCESS);
  assign o_penable   = (state == ACCESS);
  assign o_rsp_valid = (state == RESP);

  // State register.
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req_valid) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (i_pready || to_hit) state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, timeout counter and response capture.
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      o_paddr       <= '0;
      o_pwrite      <= 1'b0;
      o_pwdata      <= '0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_paddr  <= i_req_addr;
            o_pwrite <= i_req_write;
            o_pwdata <= i_req_write ? i_req_wdata : '0;
          end
        end
        SETUP: cnt <= '0;
        ACCESS: begin
          if (i_pready) begin
            o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
          end else if (to_hit) begin
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: the driver pushes the expected response
// of each command, a monitor checks the APB bus and pops on every response.
module tb_apb_master_ctrl;

  localparam int TO = 4;

  logic        i_pclk = 1'b0;
  logic        i_preset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_rsp_timeout;
  logic [31:0] o_paddr;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic        o_psel;
  logic        o_penable;
  logic [31:0] i_prdata = '0;
  logic        i_pready = 1'b0;
  logic        i_pslverr = 1'b0;

  apb_master_ctrl #(.A_WIDTH(32), .WD_WIDTH(32), .RD_WIDTH(32), .TIMEOUT(TO)) dut (
    .i_pclk(i_pclk), .i_preset(i_preset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .o_psel(o_psel), .o_penable(o_penable),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 i_pclk = ~i_pclk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   bp_hold = 0;
  bit   rand_bp = 1'b0;

  // slave behaviour for the current transfer
  int          cur_waits = 0;
  logic        cur_err = 1'b0;
  logic [31:0] cur_prdata = '0;
  int          acc_n = 0;

  always @(posedge i_pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slave: pready asserted on ACCESS cycle cur_waits+1.
  always @(negedge i_pclk) begin
    if (o_psel && o_penable) begin
      acc_n++;
      i_pready  = (acc_n == cur_waits + 1);
      i_pslverr = i_pready ? cur_err : 1'b0;
      i_prdata  = cur_prdata;
    end else begin
      acc_n     = 0;
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      i_prdata  = $urandom;
    end
  end

  // Monitor: APB bus vs. scoreboard head, then response check and pop.
  bit prev_valid = 1'b0;
  bit prev_psel = 1'b0;
  always @(negedge i_pclk) begin
    if (!i_preset) begin
      if (o_psel) begin
        if (sb.size() == 0) chk("apb_without_txn", 1, 0);
        else begin
          chk("apb_bus", {o_paddr, o_pwdata}, {sb[0].addr, sb[0].write ? sb[0].wdata : 32'h0});
          chk("apb_pwrite", o_pwrite, sb[0].write);
        end
        if (!o_penable) chk("apb_setup_once", prev_psel, 0);
      end
      if (o_rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          if (!prev_valid) chk("rsp_latency", cyc - acc_cyc, sb[0].lat);
          chk("rsp_rdata", o_rsp_rdata, sb[0].rdata);
          chk("rsp_err_to", {o_rsp_err, o_rsp_timeout}, {sb[0].err, sb[0].to});
          chk("req_ready_busy", o_req_ready, 0);
        end
        if (bp_hold > 0) begin
          i_rsp_ready = 1'b0;
          bp_hold--;
        end else begin
          i_rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (i_rsp_ready && sb.size() > 0) void'(sb.pop_front());
      end else begin
        i_rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    prev_valid = o_rsp_valid;
    prev_psel  = o_psel;
  end

  // Issue one command and push its expected response from the transfer rules.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic perr, input logic [31:0] prd);
    exp_t e;
    int   n;
    n = 0;
    @(negedge i_pclk);
    while (!o_req_ready && n < 200) begin
      @(negedge i_pclk);
      n++;
    end
    if (!o_req_ready) begin
      $display("FAIL req_ready_wait: got 0 expected 1");
      fails++;
      tests++;
      return;
    end
    cur_waits  = waits;
    cur_err    = perr;
    cur_prdata = prd;
    e.write = wr;
    e.addr  = addr;
    e.wdata = wd;
    e.to    = (waits >= TO);
    e.rdata = (e.to || wr) ? 32'h0 : prd;
    e.err   = e.to ? 1'b1 : perr;
    e.lat   = e.to ? 1 + TO : 2 + waits;
    sb.push_back(e);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_wdata = wd;
    @(posedge i_pclk);
    #1;
    acc_cyc = cyc;
    i_req_valid = 1'b0;
    i_req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge i_pclk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_ctrl", {o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err, o_rsp_timeout}, 0);
    chk("rst_data", {o_paddr, o_pwdata, o_rsp_rdata}, 0);
    @(negedge i_pclk);
    i_preset = 1'b0;
    #1;
    chk("rst_req_ready", o_req_ready, 1);

    // zero-wait write
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    // read with 3 wait states
    do_txn(1'b0, 32'h24, 32'h0, 3, 1'b0, 32'hCAFE0001);
    // slave error on write
    do_txn(1'b1, 32'h30, 32'h12345678, 0, 1'b1, 32'h0);
    // timeout: pready never comes
    do_txn(1'b0, 32'h40, 32'h0, 10, 1'b0, 32'h55AA55AA);
    // pready in the last allowed ACCESS cycle wins
    do_txn(1'b0, 32'h44, 32'h0, TO - 1, 1'b0, 32'h0BADF00D);
    drain();

    // response backpressure, then a back-to-back request
    bp_hold = 5;
    do_txn(1'b0, 32'h50, 32'h0, 1, 1'b0, 32'hA5A5_0001);
    do_txn(1'b1, 32'h54, 32'hFEEDFACE, 0, 1'b0, 32'h0);
    drain();

    // reset during ACCESS wait states
    do_txn(1'b0, 32'h60, 32'h0, 10, 1'b0, 32'h1111_2222);
    repeat (2) @(negedge i_pclk);
    chk("pre_rst_access", {o_psel, o_penable}, 2'b11);
    #2 i_preset = 1'b1;
    #1;
    chk("rst_mid_apb", {o_psel, o_penable, o_rsp_valid}, 0);
    sb.delete();
    @(negedge i_pclk);
    i_preset = 1'b0;
    repeat (3) begin
      @(negedge i_pclk);
      chk("rst_no_rsp", o_rsp_valid, 0);
    end
    do_txn(1'b0, 32'h64, 32'h0, 0, 1'b0, 32'h7777_8888);
    drain();

    // randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
             1'($urandom_range(0, 1)), $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
